// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, req/ack data-memory bus master with
// byte-lane alignment, load extension, timeout abort, and the MEM/WB register.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  input  logic [4:0]  in_dest,
  input  logic [31:0] aluOut,
  input  logic [31:0] sWord,
  output logic        stall,
  output logic [31:0] memForward,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic        align_err,
  output logic        bus_err
);

  typedef enum logic {S_IDLE, S_BUS} state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        reg_valid_q, reg_valid_d;
  logic        reg_read_q, reg_read_d;
  logic        reg_write_q, reg_write_d;
  logic [1:0]  reg_size_q, reg_size_d;
  logic        reg_signed_q, reg_signed_d;
  logic [4:0]  reg_dest_q, reg_dest_d;
  logic [31:0] reg_alu_q, reg_alu_d;
  logic [31:0] reg_sword_q, reg_sword_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_dest_q, wb_dest_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        align_err_q, align_err_d;
  logic        bus_err_q, bus_err_d;

  logic        in_bus, reg_mis, in_go, timeout_hit;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      default: return |a;
    endcase
  endfunction

  assign in_bus      = (state_q == S_BUS);
  assign stall       = in_bus & ~mem_ack;
  assign timeout_hit = in_bus & ~mem_ack & (cnt_q == TMO_LAST);
  assign reg_mis     = reg_valid_q & (reg_read_q | reg_write_q) &
                       misaligned(reg_size_q, reg_alu_q[1:0]);
  // Next-state decision looks at the instruction being loaded this edge.
  assign in_go       = in_valid & (MemRead | MemWrite) & ~misaligned(MemSize, aluOut[1:0]);

  assign ld_byte = mem_rdata[{reg_alu_q[1:0], 3'b000} +: 8];
  assign ld_half = mem_rdata[{reg_alu_q[1], 4'b0000} +: 16];

  always_comb begin
    case (reg_size_q)
      2'd0:    ld_data = {{24{reg_signed_q & ld_byte[7]}}, ld_byte};
      2'd1:    ld_data = {{16{reg_signed_q & ld_half[15]}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    mem_req   = in_bus;
    mem_we    = in_bus & reg_write_q & ~reg_read_q;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (in_bus) begin
      mem_addr = reg_alu_q[31:2];
      case (reg_size_q)
        2'd0: begin
          mem_be    = 4'b0001 << reg_alu_q[1:0];
          mem_wdata = {4{reg_sword_q[7:0]}};
        end
        2'd1: begin
          mem_be    = reg_alu_q[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{reg_sword_q[15:0]}};
        end
        default: begin
          mem_be    = '1;
          mem_wdata = reg_sword_q;
        end
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    reg_valid_d  = reg_valid_q;
    reg_read_d   = reg_read_q;
    reg_write_d  = reg_write_q;
    reg_size_d   = reg_size_q;
    reg_signed_d = reg_signed_q;
    reg_dest_d   = reg_dest_q;
    reg_alu_d    = reg_alu_q;
    reg_sword_d  = reg_sword_q;
    wb_valid_d   = wb_valid_q;
    wb_dest_d    = wb_dest_q;
    wb_data_d    = wb_data_q;
    align_err_d  = 1'b0;
    bus_err_d    = 1'b0;
    if (timeout_hit) begin
      // Abort: invalidate the held op so it is not retired once stall drops.
      state_d     = S_IDLE;
      cnt_d       = '0;
      reg_valid_d = 1'b0;
      wb_valid_d  = 1'b0;
      bus_err_d   = 1'b1;
    end else if (stall) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      wb_valid_d   = reg_valid_q & ~reg_mis;
      wb_dest_d    = reg_dest_q;
      wb_data_d    = reg_read_q ? ld_data : reg_alu_q;
      align_err_d  = reg_mis;
      reg_valid_d  = in_valid;
      reg_read_d   = MemRead;
      reg_write_d  = MemWrite;
      reg_size_d   = MemSize;
      reg_signed_d = MemSigned;
      reg_dest_d   = in_dest;
      reg_alu_d    = aluOut;
      reg_sword_d  = sWord;
      state_d      = in_go ? S_BUS : S_IDLE;
      cnt_d        = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      reg_valid_q  <= 1'b0;
      reg_read_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      reg_size_q   <= '0;
      reg_signed_q <= 1'b0;
      reg_dest_q   <= '0;
      reg_alu_q    <= '0;
      reg_sword_q  <= '0;
      wb_valid_q   <= 1'b0;
      wb_dest_q    <= '0;
      wb_data_q    <= '0;
      align_err_q  <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      reg_valid_q  <= reg_valid_d;
      reg_read_q   <= reg_read_d;
      reg_write_q  <= reg_write_d;
      reg_size_q   <= reg_size_d;
      reg_signed_q <= reg_signed_d;
      reg_dest_q   <= reg_dest_d;
      reg_alu_q    <= reg_alu_d;
      reg_sword_q  <= reg_sword_d;
      wb_valid_q   <= wb_valid_d;
      wb_dest_q    <= wb_dest_d;
      wb_data_q    <= wb_data_d;
      align_err_q  <= align_err_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign memForward = reg_alu_q;
  assign wb_valid   = wb_valid_q;
  assign wb_dest    = wb_dest_q;
  assign wb_data    = wb_data_q;
  assign align_err  = align_err_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized ops
// compared against a lane/extension model built from plain arithmetic.
module tb_mem_stage;

  logic        clk, reset_n, in_valid, MemRead, MemWrite, MemSigned;
  logic [1:0]  MemSize;
  logic [4:0]  in_dest;
  logic [31:0] aluOut, sWord;
  logic        stall, mem_req, mem_we, mem_ack, wb_valid, align_err, bus_err;
  logic [31:0] memForward, mem_wdata, mem_rdata, wb_data;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [4:0]  wb_dest;

  int checks = 0;
  int failures = 0;

  // Observations gathered by do_op
  int          obs_req, obs_stall;
  logic        obs_unstable, obs_hung, obs_we;
  logic [29:0] obs_addr;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata, obs_fwd, obs_wb_data;
  logic        obs_wb_valid, obs_align, obs_align2, obs_bus, obs_bus2, obs_stall_after, obs_req_after;
  logic [4:0]  obs_wb_dest;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemSize(MemSize), .MemSigned(MemSigned),
    .in_dest(in_dest), .aluOut(aluOut), .sWord(sWord), .stall(stall),
    .memForward(memForward), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_valid(wb_valid),
    .wb_dest(wb_dest), .wb_data(wb_data), .align_err(align_err), .bus_err(bus_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
    int nb = nbytes(sz);
    int sh = (nb == 4) ? 0 : int'(a % 4);
    return 4'(((1 << nb) - 1) << sh);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] sw);
    logic [31:0] r;
    int nb = nbytes(sz);
    r = '0;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = sw[8*(k % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg,
                                             input logic [31:0] a, input logic [31:0] rd);
    longint v;
    int nb = nbytes(sz);
    if (nb == 4) return rd;
    v = (longint'(rd) >> (8 * (a % 4))) % (longint'(1) << (8 * nb));
    if (sg && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  task automatic idle_inputs();
    in_valid = 0; MemRead = 0; MemWrite = 0; MemSize = 0; MemSigned = 0;
    in_dest = 0; aluOut = $urandom; sWord = $urandom;
  endtask

  // Runs one op from IDLE. lat = req cycle on which ack is given (0 = never).
  task automatic do_op(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [4:0] dst, input logic [31:0] a, input logic [31:0] sw,
                       input int lat, input logic [31:0] rdat);
    logic st, done;
    in_valid = 1; MemRead = rd; MemWrite = wr; MemSize = sz; MemSigned = sg;
    in_dest = dst; aluOut = a; sWord = sw; mem_ack = 0;
    @(posedge clk); #1;
    idle_inputs();
    obs_fwd = memForward;
    obs_req = 0; obs_stall = 0; obs_unstable = 0; done = 0;
    obs_addr = '0; obs_be = '0; obs_we = 0; obs_wdata = '0;
    for (int c = 0; c < 40; c++) begin
      if (mem_req) begin
        obs_req++;
        if (obs_req == 1) begin
          obs_addr = mem_addr; obs_be = mem_be; obs_we = mem_we; obs_wdata = mem_wdata;
        end else if ({mem_addr, mem_be, mem_we, mem_wdata} !== {obs_addr, obs_be, obs_we, obs_wdata})
          obs_unstable = 1;
        if (obs_req == lat) begin mem_ack = 1; mem_rdata = rdat; end
      end
      #1; st = stall;
      if (st) obs_stall++;
      @(posedge clk); #1;
      mem_ack = 0; mem_rdata = $urandom;
      if (!st || !mem_req) begin done = 1; break; end
    end
    obs_hung = !done;
    obs_wb_valid = wb_valid; obs_wb_dest = wb_dest; obs_wb_data = wb_data;
    obs_align = align_err; obs_bus = bus_err;
    obs_stall_after = stall; obs_req_after = mem_req;
    @(posedge clk); #1;
    obs_align2 = align_err; obs_bus2 = bus_err;
  endtask

  task automatic test_reset();
    reset_n = 0; mem_ack = 0; mem_rdata = 0; idle_inputs();
    repeat (2) @(posedge clk); #1;
    checks++; if ({stall, mem_req, mem_we, mem_be, mem_addr} !== '0) begin failures++;
      $display("FAIL reset_bus: got stall=%b req=%b we=%b be=%h addr=%h required all 0", stall, mem_req, mem_we, mem_be, mem_addr); end
    checks++; if ({mem_wdata, memForward} !== '0) begin failures++;
      $display("FAIL reset_data: got wdata=%h fwd=%h required 0", mem_wdata, memForward); end
    checks++; if ({wb_valid, wb_dest, wb_data, align_err, bus_err} !== '0) begin failures++;
      $display("FAIL reset_wb: got v=%b d=%0d data=%h ae=%b be=%b required all 0", wb_valid, wb_dest, wb_data, align_err, bus_err); end
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    do_op(0, 0, 2'd2, 0, 5'd5, 32'h12345678, 32'h0, 1, 32'h0);
    checks++; if (obs_fwd !== 32'h12345678) begin failures++;
      $display("FAIL alu_fwd: got %h required 12345678", obs_fwd); end
    checks++; if ({obs_wb_valid, obs_wb_dest, obs_wb_data} !== {1'b1, 5'd5, 32'h12345678}) begin failures++;
      $display("FAIL alu_wb: got v=%b d=%0d data=%h required 1/5/12345678", obs_wb_valid, obs_wb_dest, obs_wb_data); end
    checks++; if (obs_stall != 0 || obs_req != 0) begin failures++;
      $display("FAIL alu_nostall: got stall=%0d req=%0d required 0/0", obs_stall, obs_req); end
  endtask

  task automatic test_word_load();
    do_op(1, 0, 2'd2, 0, 5'd9, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    checks++; if ({obs_addr, obs_be, obs_we} !== {30'h40, 4'b1111, 1'b0}) begin failures++;
      $display("FAIL wload_bus: got addr=%h be=%b we=%b required 40/1111/0", obs_addr, obs_be, obs_we); end
    checks++; if (obs_stall != 2) begin failures++;
      $display("FAIL wload_stall: got %0d required 2", obs_stall); end
    checks++; if ({obs_wb_valid, obs_wb_data} !== {1'b1, 32'hDEADBEEF}) begin failures++;
      $display("FAIL wload_wb: got v=%b data=%h required 1/deadbeef", obs_wb_valid, obs_wb_data); end
  endtask

  task automatic test_byte_load();
    do_op(1, 0, 2'd0, 1, 5'd3, 32'h103, 32'h0, 1, 32'h80FFFFFF);
    checks++; if (obs_be !== 4'b1000 || obs_stall != 0) begin failures++;
      $display("FAIL bload_be: got be=%b stall=%0d required 1000/0", obs_be, obs_stall); end
    checks++; if (obs_wb_data !== 32'hFFFFFF80) begin failures++;
      $display("FAIL bload_signed: got %h required ffffff80", obs_wb_data); end
    do_op(1, 0, 2'd0, 0, 5'd3, 32'h103, 32'h0, 1, 32'h80FFFFFF);
    checks++; if (obs_wb_data !== 32'h00000080) begin failures++;
      $display("FAIL bload_unsigned: got %h required 00000080", obs_wb_data); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1; MemRead = 0; MemWrite = 1; MemSize = 2'd1; MemSigned = 0;
    in_dest = 0; aluOut = 32'h202; sWord = 32'h0000ABCD; mem_ack = 0;
    @(posedge clk); #1;
    MemSize = 2'd2; aluOut = 32'h300; sWord = 32'h11223344;
    checks++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b1100, 30'h80, 32'hABCDABCD}) begin failures++;
      $display("FAIL b2b_first: got req=%b we=%b be=%b addr=%h wdata=%h required 1/1/1100/80/abcdabcd", mem_req, mem_we, mem_be, mem_addr, mem_wdata); end
    mem_ack = 1;
    @(posedge clk); #1;
    mem_ack = 0; idle_inputs();
    checks++; if ({mem_req, mem_be, mem_addr, mem_wdata} !== {1'b1, 4'b1111, 30'hC0, 32'h11223344}) begin failures++;
      $display("FAIL b2b_second: got req=%b be=%b addr=%h wdata=%h required 1/1111/c0/11223344", mem_req, mem_be, mem_addr, mem_wdata); end
    checks++; if ({wb_valid, wb_dest, wb_data} !== {1'b1, 5'd0, 32'h202}) begin failures++;
      $display("FAIL b2b_wb: got v=%b d=%0d data=%h required 1/0/00000202", wb_valid, wb_dest, wb_data); end
    mem_ack = 1;
    @(posedge clk); #1;
    mem_ack = 0;
    checks++; if (mem_req !== 1'b0 || wb_data !== 32'h300) begin failures++;
      $display("FAIL b2b_end: got req=%b wb_data=%h required 0/00000300", mem_req, wb_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned();
    do_op(1, 0, 2'd2, 0, 5'd7, 32'h101, 32'h0, 1, 32'h0);
    checks++; if (obs_req != 0) begin failures++;
      $display("FAIL mis_noreq: got %0d req cycles required 0", obs_req); end
    checks++; if ({obs_align, obs_align2, obs_wb_valid} !== 3'b100) begin failures++;
      $display("FAIL mis_pulse: got ae=%b,%b wb_valid=%b required 1,0 and 0", obs_align, obs_align2, obs_wb_valid); end
  endtask

  task automatic test_timeout();
    do_op(1, 0, 2'd2, 0, 5'd4, 32'h40, 32'h0, 0, 32'h0);
    checks++; if (obs_req != 4 || obs_hung) begin failures++;
      $display("FAIL tmo_req: got %0d req cycles (hung=%b) required 4", obs_req, obs_hung); end
    checks++; if ({obs_bus, obs_bus2, obs_wb_valid} !== 3'b100) begin failures++;
      $display("FAIL tmo_pulse: got be=%b,%b wb_valid=%b required 1,0 and 0", obs_bus, obs_bus2, obs_wb_valid); end
    checks++; if ({obs_stall_after, obs_req_after} !== 2'b00) begin failures++;
      $display("FAIL tmo_idle: got stall=%b req=%b required 0/0", obs_stall_after, obs_req_after); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1; MemRead = 1; MemWrite = 0; MemSize = 2'd2; in_dest = 5'd6;
    aluOut = 32'h10; mem_ack = 0;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #2;
    reset_n = 0; #1;
    checks++; if ({stall, mem_req, mem_we, mem_be, mem_addr, mem_wdata, memForward} !== '0) begin failures++;
      $display("FAIL rstmid_bus: got stall=%b req=%b be=%b addr=%h fwd=%h required 0", stall, mem_req, mem_be, mem_addr, memForward); end
    checks++; if ({wb_valid, wb_dest, wb_data, align_err, bus_err} !== '0) begin failures++;
      $display("FAIL rstmid_wb: got v=%b d=%0d data=%h required 0", wb_valid, wb_dest, wb_data); end
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
    do_op(1, 0, 2'd1, 1, 5'd8, 32'h22, 32'h0, 2, 32'h9876_5432);
    checks++; if ({obs_wb_valid, obs_wb_data, obs_stall} !== {1'b1, 32'hFFFF9876, 32'd1}) begin failures++;
      $display("FAIL rstmid_after: got v=%b data=%h stall=%0d required 1/ffff9876/1", obs_wb_valid, obs_wb_data, obs_stall); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      logic rd, wr, sg, mis, go, tmo, exp_v;
      logic [1:0] sz;
      logic [4:0] dst;
      logic [31:0] a, sw, rdat, exp_d;
      int k, lat, nb, exp_req, exp_stall;
      k = $urandom_range(0, 3);
      rd = (k == 1 || k == 3); wr = (k == 2 || k == 3);
      sz = 2'($urandom_range(0, 3)); sg = 1'($urandom_range(0, 1));
      dst = 5'($urandom); a = $urandom; sw = $urandom; rdat = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      lat = $urandom_range(0, 3);
      nb = nbytes(sz);
      mis = (rd || wr) && (a % nb != 0);
      go = (rd || wr) && !mis;
      tmo = go && lat == 0;
      exp_req = !go ? 0 : (lat == 0) ? 4 : lat;
      exp_stall = !go ? 0 : (lat == 0) ? 4 : lat - 1;
      exp_v = !mis && !tmo;
      exp_d = rd ? model_load(sz, sg, a, rdat) : a;
      do_op(rd, wr, sz, sg, dst, a, sw, lat, rdat);
      checks++; if (obs_req != exp_req || obs_stall != exp_stall || obs_hung) begin failures++;
        $display("FAIL rnd_timing[%0d]: got req=%0d stall=%0d hung=%b required req=%0d stall=%0d", n, obs_req, obs_stall, obs_hung, exp_req, exp_stall); end
      checks++; if (obs_fwd !== a) begin failures++;
        $display("FAIL rnd_fwd[%0d]: got %h required %h", n, obs_fwd, a); end
      checks++; if ({obs_align, obs_align2, obs_bus, obs_bus2} !== {mis, 1'b0, tmo, 1'b0}) begin failures++;
        $display("FAIL rnd_err[%0d]: got ae=%b,%b be=%b,%b required %b,0 %b,0", n, obs_align, obs_align2, obs_bus, obs_bus2, mis, tmo); end
      checks++; if (obs_wb_valid !== exp_v) begin failures++;
        $display("FAIL rnd_wbv[%0d]: got %b required %b", n, obs_wb_valid, exp_v); end
      if (exp_v) begin
        checks++; if ({obs_wb_dest, obs_wb_data} !== {dst, exp_d}) begin failures++;
          $display("FAIL rnd_wb[%0d]: got d=%0d data=%h required d=%0d data=%h", n, obs_wb_dest, obs_wb_data, dst, exp_d); end
      end
      if (go) begin
        checks++; if ({obs_addr, obs_be, obs_we, obs_unstable} !== {a[31:2], model_be(sz, a), wr && !rd, 1'b0}) begin failures++;
          $display("FAIL rnd_bus[%0d]: got addr=%h be=%b we=%b unstable=%b required addr=%h be=%b we=%b", n, obs_addr, obs_be, obs_we, obs_unstable, a[31:2], model_be(sz, a), wr && !rd); end
        if (wr && !rd) begin
          checks++; if (obs_wdata !== model_wdata(sz, sw)) begin failures++;
            $display("FAIL rnd_wdata[%0d]: got %h required %h", n, obs_wdata, model_wdata(sz, sw)); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_word_load();
    test_byte_load();
    test_back_to_back();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
